// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP     = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA_H = 3'd3,
    ST_DATA_L = 3'd4,
    ST_CSUM   = 3'd5
  } state_e;

  localparam int FRAME_LEN = 6;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  // One byte-time on the line is 10 bit periods (start + 8 data + stop).
  function automatic logic [31:0] timeout_cycles(input logic [31:0] clk_freq,
                                                 input logic [31:0] baud,
                                                 input logic [31:0] bytes);
    return (clk_freq / baud) * 32'd10 * bytes;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / command-out bus between the UART receive path and the frame parser.
interface uart_frame_parser_if;

  logic [7:0]  uart_rx_data;
  logic        uart_rx_done;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic        frame_timeout;
  logic        busy;

  // Byte source and command consumer.
  modport master (
    output uart_rx_data,
    output uart_rx_done,
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    input  frame_err,
    input  frame_timeout,
    input  busy
  );

  // The parser itself.
  modport slave (
    input  uart_rx_data,
    input  uart_rx_done,
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    output frame_err,
    output frame_timeout,
    output busy
  );

endinterface

// File: rtl/uart_frame_parser.sv
// Assembles 6-byte AA/op/addr/dh/dl/csum frames; cmd_valid one cycle after the checksum strobe.
// No backpressure: every byte strobe is consumed the cycle it arrives.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ      = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD     = 32'd115200,
  parameter logic [31:0] TIMEOUT_BYTES = 32'd4,
  parameter logic [7:0]  HEADER        = DEFAULT_HEADER
) (
  input logic                clk_in,
  input logic                rst_in,
  uart_frame_parser_if.slave bus
);

  localparam logic [31:0] TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, UART_BAUD, TIMEOUT_BYTES);
  localparam int          CNT_W          = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  state_e           state_q;
  logic [7:0]       acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       op_q;
  logic [7:0]       addr_q;
  logic [7:0]       data_h_q;
  logic [7:0]       data_l_q;
  logic             cmd_valid_q;
  logic [7:0]       cmd_op_q;
  logic [7:0]       cmd_addr_q;
  logic [15:0]      cmd_data_q;
  logic             frame_err_q;
  logic             frame_timeout_q;

  logic [7:0]       acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             csum_ok;
  logic             timeout_hit;

  always_comb begin
    acc_d       = acc_q + bus.uart_rx_data;
    cnt_d       = cnt_q + CNT_W'(1);
    csum_ok     = (bus.uart_rx_data == acc_q);
    // A byte landing on the expiry cycle takes priority over the timeout.
    timeout_hit = (state_q != ST_IDLE) && !bus.uart_rx_done && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      acc_q           <= '0;
      cnt_q           <= '0;
      op_q            <= '0;
      addr_q          <= '0;
      data_h_q        <= '0;
      data_l_q        <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_op_q        <= '0;
      cmd_addr_q      <= '0;
      cmd_data_q      <= '0;
      frame_err_q     <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      cmd_valid_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_timeout_q <= 1'b0;

      if (bus.uart_rx_done) begin
        cnt_q <= '0;
        unique case (state_q)
          ST_IDLE: begin
            if (bus.uart_rx_data == HEADER) begin
              state_q <= ST_OP;
              acc_q   <= '0;
            end
          end
          ST_OP: begin
            op_q    <= bus.uart_rx_data;
            acc_q   <= acc_d;
            state_q <= ST_ADDR;
          end
          ST_ADDR: begin
            addr_q  <= bus.uart_rx_data;
            acc_q   <= acc_d;
            state_q <= ST_DATA_H;
          end
          ST_DATA_H: begin
            data_h_q <= bus.uart_rx_data;
            acc_q    <= acc_d;
            state_q  <= ST_DATA_L;
          end
          ST_DATA_L: begin
            data_l_q <= bus.uart_rx_data;
            acc_q    <= acc_d;
            state_q  <= ST_CSUM;
          end
          ST_CSUM: begin
            if (csum_ok) begin
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= op_q;
              cmd_addr_q  <= addr_q;
              cmd_data_q  <= {data_h_q, data_l_q};
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else if (timeout_hit) begin
        state_q         <= ST_IDLE;
        frame_timeout_q <= 1'b1;
        cnt_q           <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_op        = cmd_op_q;
  assign bus.cmd_addr      = cmd_addr_q;
  assign bus.cmd_data      = cmd_data_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.frame_timeout = frame_timeout_q;
  assign bus.busy          = (state_q != ST_IDLE);

  a_flags_exclusive: assert property (@(posedge clk_in) disable iff (rst_in)
    $onehot0({cmd_valid_q, frame_err_q, frame_timeout_q}));

  a_state_in_range: assert property (@(posedge clk_in)
    int'(state_q) < FRAME_LEN);

endmodule
